iob_eth_rx_ctrl: RTL

//  System-clock-domain controller that sequences the Ethernet receiver frame by frame.

---
 rtl/iob_eth_rx_ctrl_pkg.sv | 30 +++
 rtl/iob_eth_rx_ctrl_if.sv | 33 +++
 rtl/iob_eth_rx_ctrl_sync.sv | 25 ++
 rtl/iob_eth_rx_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/iob_eth_rx_ctrl_pkg.sv
// Shared types and constants for the Ethernet RX frame controller.
// Optional MAC filtering is enabled by defining IOB_ETH_RX_MAC_FILTER_EN.
package iob_eth_rx_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CHECK    = 3'd1,
    ST_FILTER   = 3'd2,
    ST_READY    = 3'd3,
    ST_ACK      = 3'd4,
    ST_WAIT_CLR = 3'd5
  } rx_state_e;

  localparam int unsigned BUF_ADDR_W = 11;
  localparam int unsigned CRC_W      = 32;
  localparam int unsigned MAC_W      = 48;

  localparam logic [CRC_W-1:0] CRC_RESIDUE_DEF = 32'hC704DD7B;
  localparam logic [MAC_W-1:0] BCAST_ADDR      = 48'hFFFF_FFFF_FFFF;

  localparam logic [MAC_W-1:0] ETH_MAC_ADDR_DEF = 48'h0200_0000_0001;

  // Byte idx of a MAC address, idx 0 being the most significant (first on the wire)
  function automatic logic [7:0] mac_byte(input logic [MAC_W-1:0] mac, input logic [2:0] idx);
    logic [MAC_W-1:0] sh;
    sh = mac << (6'(idx) * 6'd8);
    return sh[MAC_W-1 -: 8];
  endfunction

endpackage

// File: rtl/iob_eth_rx_ctrl_if.sv
// Receiver, frame-buffer and host-side signals of the RX frame controller.
interface iob_eth_rx_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  import iob_eth_rx_ctrl_pkg::*;

  logic                  data_rcvd;
  logic [CRC_W-1:0]      crc_value;
  logic                  rcv_ack;
  logic [BUF_ADDR_W-1:0] buf_addr;
  logic [7:0]            buf_rdata;
  logic                  host_rx_ready;
  logic                  host_rx_crc_ok;
  logic                  host_rx_release;
  logic [CNT_W-1:0]      rx_good_cnt;
  logic [CNT_W-1:0]      rx_bad_cnt;
  logic [CNT_W-1:0]      rx_drop_cnt;

  // Controller side
  modport master (
    input  data_rcvd, crc_value, buf_rdata, host_rx_release,
    output rcv_ack, buf_addr, host_rx_ready, host_rx_crc_ok,
           rx_good_cnt, rx_bad_cnt, rx_drop_cnt
  );

  // Receiver / buffer / host side
  modport slave (
    output data_rcvd, crc_value, buf_rdata, host_rx_release,
    input  rcv_ack, buf_addr, host_rx_ready, host_rx_crc_ok,
           rx_good_cnt, rx_bad_cnt, rx_drop_cnt
  );

endinterface

// File: rtl/iob_eth_rx_ctrl_sync.sv
// Two-flop level synchronizer bringing data_rcvd into the system clock domain.
module iob_eth_rx_ctrl_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Metastability filter chain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/iob_eth_rx_ctrl.sv
// Ethernet RX frame controller: CRC check, optional destination-MAC filter,
// host handoff and receiver re-arm acknowledge.
// Define IOB_ETH_RX_MAC_FILTER_EN to build in the destination-MAC filter.
module iob_eth_rx_ctrl
  import iob_eth_rx_ctrl_pkg::*;
#(
  parameter logic [MAC_W-1:0] ETH_MAC_ADDR = ETH_MAC_ADDR_DEF,
  parameter logic [CRC_W-1:0] CRC_RESIDUE  = CRC_RESIDUE_DEF,
  parameter int unsigned      ACK_CYCLES   = 4,
  parameter int unsigned      CNT_W        = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  iob_eth_rx_ctrl_if.master    rx_if
);

  localparam int unsigned ACK_W = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_CYCLES - 1);
  localparam logic [2:0] FILT_LAST = 3'd6;

  rx_state_e        state_q, state_d;
  logic [ACK_W-1:0] ack_cnt_q, ack_cnt_d;
  logic [2:0]       fidx_q, fidx_d;
  logic             mac_ok_q, mac_ok_d;
  logic             bc_ok_q, bc_ok_d;
  logic             crc_ok_q, crc_ok_d;
  logic             ready_q, ready_d;
  logic             hcrc_q, hcrc_d;
  logic             rcv_ack_q, rcv_ack_d;
  logic [CNT_W-1:0] good_q, good_d;
  logic [CNT_W-1:0] bad_q, bad_d;
  logic [7:0]       byte_exp;
  logic             mac_hit;
  logic             bc_hit;
  logic             rcvd_s;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
  logic                  drop_inc;
  logic [BUF_ADDR_W-1:0] buf_addr_q, buf_addr_d;
  logic [CNT_W-1:0]      drop_q, drop_d;
`endif

  iob_eth_rx_ctrl_sync u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rx_if.data_rcvd),
    .q_o   (rcvd_s)
  );

  // Next-state, counters and registered-output decode
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = '0;
    fidx_d    = '0;
    mac_ok_d  = mac_ok_q;
    bc_ok_d   = bc_ok_q;
    crc_ok_d  = crc_ok_q;
    good_d    = good_q;
    bad_d     = bad_q;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
    drop_inc  = 1'b0;
`endif
    // Byte returned this cycle belongs to the address issued one cycle earlier
    byte_exp  = mac_byte(ETH_MAC_ADDR, fidx_q - 3'd1);
    mac_hit   = (rx_if.buf_rdata == byte_exp);
    bc_hit    = (rx_if.buf_rdata == BCAST_ADDR[7:0]);

    case (state_q)
      ST_IDLE: begin
        if (rcvd_s) state_d = ST_CHECK;
      end
      ST_CHECK: begin
        crc_ok_d = (rx_if.crc_value == CRC_RESIDUE);
        mac_ok_d = 1'b1;
        bc_ok_d  = 1'b1;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
        state_d  = ST_FILTER;
`else
        state_d  = ST_READY;
`endif
      end
      ST_FILTER: begin
        fidx_d = fidx_q + 3'd1;
        if (fidx_q != 3'd0) begin
          mac_ok_d = mac_ok_q & mac_hit;
          bc_ok_d  = bc_ok_q & bc_hit;
        end
        if (fidx_q == FILT_LAST) begin
          fidx_d = '0;
          if (mac_ok_d || bc_ok_d) begin
            state_d = ST_READY;
          end else begin
            state_d = ST_ACK;
`ifdef IOB_ETH_RX_MAC_FILTER_EN
            drop_inc = 1'b1;
`endif
          end
        end
      end
      ST_READY: begin
        if (rx_if.host_rx_release) begin
          state_d = ST_ACK;
          if (crc_ok_q) begin
            if (good_q != '1) good_d = good_q + CNT_W'(1);
          end else begin
            if (bad_q != '1) bad_d = bad_q + CNT_W'(1);
          end
        end
      end
      ST_ACK: begin
        ack_cnt_d = ack_cnt_q + ACK_W'(1);
        if (ack_cnt_q == ACK_LAST) begin
          ack_cnt_d = '0;
          state_d   = ST_WAIT_CLR;
        end
      end
      ST_WAIT_CLR: begin
        // Hold off until the receiver drops its flag so one frame counts once
        if (!rcvd_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    ready_d   = (state_d == ST_READY);
    hcrc_d    = ready_d & crc_ok_d;
    rcv_ack_d = (state_d == ST_ACK);
  end

  // State and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      ack_cnt_q <= '0;
      fidx_q    <= '0;
      mac_ok_q  <= 1'b0;
      bc_ok_q   <= 1'b0;
      crc_ok_q  <= 1'b0;
      ready_q   <= 1'b0;
      hcrc_q    <= 1'b0;
      rcv_ack_q <= 1'b0;
      good_q    <= '0;
      bad_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      fidx_q    <= fidx_d;
      mac_ok_q  <= mac_ok_d;
      bc_ok_q   <= bc_ok_d;
      crc_ok_q  <= crc_ok_d;
      ready_q   <= ready_d;
      hcrc_q    <= hcrc_d;
      rcv_ack_q <= rcv_ack_d;
      good_q    <= good_d;
      bad_q     <= bad_d;
    end
  end

`ifdef IOB_ETH_RX_MAC_FILTER_EN
  // Buffer address walks bytes 0..5 while filtering, parked at 0 otherwise
  always_comb begin
    buf_addr_d = '0;
    if ((state_d == ST_FILTER) && (fidx_d < FILT_LAST)) buf_addr_d = BUF_ADDR_W'(fidx_d);
    drop_d = drop_q;
    if (drop_inc && (drop_q != '1)) drop_d = drop_q + CNT_W'(1);
  end

  // Filter address and drop counter registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_addr_q <= '0;
      drop_q     <= '0;
    end else begin
      buf_addr_q <= buf_addr_d;
      drop_q     <= drop_d;
    end
  end

  assign rx_if.buf_addr    = buf_addr_q;
  assign rx_if.rx_drop_cnt = drop_q;
`else
  assign rx_if.buf_addr    = '0;
  assign rx_if.rx_drop_cnt = '0;
`endif

  assign rx_if.rcv_ack        = rcv_ack_q;
  assign rx_if.host_rx_ready  = ready_q;
  assign rx_if.host_rx_crc_ok = hcrc_q;
  assign rx_if.rx_good_cnt    = good_q;
  assign rx_if.rx_bad_cnt     = bad_q;

endmodule
